// File: rtl/spi_flash_arbiter.sv
// Two-requester round-robin arbiter that serves 32-bit reads from a SPI flash
// using the 0x03 READ command in SPI mode 0.
`timescale 1ns/1ps
module spi_flash_arbiter #(
  parameter logic [23:0] SPI_FLASH_BASE = 24'h500000,
  parameter int unsigned CLK_DIV        = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        req0_valid,
  input  logic [23:0] req0_addr,
  output logic        req0_ready,
  output logic [31:0] req0_rdata,
  input  logic        req1_valid,
  input  logic [23:0] req1_addr,
  output logic        req1_ready,
  output logic [31:0] req1_rdata,
  output logic        busy,
  output logic        spi_cs,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int unsigned DIV_W = (2 * CLK_DIV > 2) ? $clog2(2 * CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone, StGap} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [DIV_W-1:0] r_div;
  logic [5:0]       r_bit;
  logic             r_gap;
  logic             r_gnt;
  logic             r_last;
  logic [31:0]      r_tx;
  logic [31:0]      r_rx;
  logic [31:0]      r_rdata0;
  logic [31:0]      r_rdata1;

  logic        w_req_any;
  logic        w_grant;
  logic [23:0] w_flash_addr;
  logic        w_bit_end;
  logic        w_frame_end;
  logic        w_sample;
  logic [31:0] w_rx_next;
  logic [31:0] w_rx_le;

  assign w_req_any    = req0_valid | req1_valid;
  // On a tie the requester not granted last wins; a lone requester always wins.
  assign w_grant      = (req0_valid && req1_valid) ? ~r_last : req1_valid;
  assign w_flash_addr = (w_grant ? req1_addr : req0_addr) + SPI_FLASH_BASE;

  assign w_bit_end   = (r_div == DIV_LAST);
  assign w_frame_end = (r_state == StShift) && w_bit_end && (r_bit == 6'd63);
  assign w_sample    = (r_state == StShift) && (r_div == DIV_HALF) && r_bit[5];
  assign w_rx_next   = w_sample ? {r_rx[30:0], spi_miso} : r_rx;
  // Bytes arrive MSB first; the first byte received lands in bits [7:0].
  assign w_rx_le     = {w_rx_next[7:0], w_rx_next[15:8], w_rx_next[23:16], w_rx_next[31:24]};

  assign req0_rdata = r_rdata0;
  assign req1_rdata = r_rdata1;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b1;
    spi_cs       = 1'b1;
    spi_clk      = 1'b0;
    spi_mosi     = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    unique case (r_state)
      StIdle: begin
        busy = 1'b0;
        if (w_req_any) begin
          w_state_next = StShift;
        end
      end
      StShift: begin
        spi_cs   = 1'b0;
        spi_clk  = (r_div >= DIV_HALF);
        spi_mosi = ~r_bit[5] & r_tx[31];
        if (w_frame_end) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        req0_ready   = ~r_gnt;
        req1_ready   = r_gnt;
        w_state_next = StGap;
      end
      StGap: begin
        if (r_gap) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_div    <= '0;
      r_bit    <= '0;
      r_gap    <= 1'b0;
      r_gnt    <= 1'b0;
      r_last   <= 1'b1;
      r_tx     <= '0;
      r_rx     <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      if (r_state == StIdle) begin
        r_div <= '0;
        r_bit <= '0;
        r_gap <= 1'b0;
        if (w_req_any) begin
          r_gnt  <= w_grant;
          r_last <= w_grant;
          r_tx   <= {8'h03, w_flash_addr};
        end
      end
      if (r_state == StShift) begin
        r_rx  <= w_rx_next;
        r_div <= w_bit_end ? '0 : r_div + 1'b1;
        if (w_bit_end) begin
          r_bit <= r_bit + 6'd1;
          r_tx  <= {r_tx[30:0], 1'b0};
        end
        if (w_frame_end) begin
          if (r_gnt) begin
            r_rdata1 <= w_rx_le;
          end else begin
            r_rdata0 <= w_rx_le;
          end
        end
      end
      if (r_state == StGap) begin
        r_gap <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Bench for spi_flash_arbiter: a SPI flash model plus a transaction-level
// reference of arbitration, latency, addressing and read data.
`timescale 1ns/1ps
module tb_spi_flash_arbiter;

  localparam int unsigned CLK_DIV = 2;
  localparam int          PERIOD  = 10;
  localparam int          LAT     = 1 + 128 * CLK_DIV;
  localparam logic [31:0] BASE    = 32'h500000;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [23:0] req0_addr = '0, req1_addr = '0;
  logic        req0_ready, req1_ready, busy, spi_cs, spi_clk, spi_mosi;
  logic        spi_miso = 1'b0;
  logic [31:0] req0_rdata, req1_rdata;

  spi_flash_arbiter #(.SPI_FLASH_BASE(24'h500000), .CLK_DIV(CLK_DIV)) u_dut (
    .clk(clk), .n_reset(n_reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .req1_rdata(req1_rdata),
    .busy(busy), .spi_cs(spi_cs), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );

  always #(PERIOD / 2) clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flash memory contents: a fixed pattern for the directed case, else a salted hash.
  logic       fixed_mode = 1'b0;
  logic [7:0] salt;

  function automatic logic [7:0] fbyte(input logic [23:0] a);
    return (a[7:0] * 8'd7) ^ a[15:8] ^ a[23:16] ^ salt;
  endfunction

  function automatic logic [31:0] fword(input logic [23:0] fa);
    if (fixed_mode) return 32'h44332211;
    return {fbyte(fa + 24'd3), fbyte(fa + 24'd2), fbyte(fa + 24'd1), fbyte(fa)};
  endfunction

  // SPI flash model: captures command/address on rising spi_clk, drives data after falling.
  int          fl_cnt;
  logic [31:0] fl_sh;
  logic [31:0] fl_word;
  logic        fl_mosi_rd, fl_bad;
  time         t_cs, t_p, t_prev, t_n;

  initial begin
    forever begin
      @(negedge spi_cs);
      t_cs = $time; fl_cnt = 0; fl_sh = '0; fl_mosi_rd = 1'b0; fl_bad = 1'b0;
      while (1) begin
        @(posedge spi_clk or posedge spi_cs);
        t_p = $time;
        #1;
        if (spi_cs) break;
        if (fl_cnt == 0) begin
          if (t_p - t_cs != CLK_DIV * PERIOD) fl_bad = 1'b1;
        end else if (t_p - t_prev != 2 * CLK_DIV * PERIOD) begin
          fl_bad = 1'b1;
        end
        t_prev = t_p;
        if (fl_cnt < 32) fl_sh = {fl_sh[30:0], spi_mosi};
        else if (spi_mosi) fl_mosi_rd = 1'b1;
        fl_cnt++;
        if (fl_cnt == 32) fl_word = fword(fl_sh[23:0]);
        @(negedge spi_clk or posedge spi_cs);
        t_n = $time;
        #1;
        if (spi_cs) break;
        if (t_n - t_p != CLK_DIV * PERIOD) fl_bad = 1'b1;
        if (fl_cnt >= 32 && fl_cnt < 64) begin
          int j;
          j = fl_cnt - 32;
          spi_miso = fl_word[8 * (j / 8) + 7 - (j % 8)];
        end
      end
    end
  end

  // Transaction-level reference: grant, latency, address, data and rdata hold.
  int          cyc = 0;
  logic        pending = 1'b0, last_g = 1'b1, exp_g = 1'b0;
  int          acc_cyc = 0, rdy_cyc = -1000;
  logic [23:0] exp_fa = '0;
  logic [31:0] hold0 = '0, hold1 = '0, exp_w, obs_w;
  int          gnt_log[$], acc_log[$], rdy_log[$];
  logic [31:0] rd_log[$];
  int          n_ready0 = 0, n_ready1 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!n_reset) begin
      pending = 1'b0; last_g = 1'b1; hold0 = '0; hold1 = '0; rdy_cyc = -1000;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_rdata0", req0_rdata, 0);
      check_eq("rst_rdata1", req1_rdata, 0);
    end else begin
      if (req0_ready || req1_ready) begin
        check_eq("ready_expected", pending, 1);
        check_eq("ready_both", req0_ready & req1_ready, 0);
        if (pending) begin
          exp_w = fword(exp_fa);
          obs_w = exp_g ? req1_rdata : req0_rdata;
          check_eq("latency", cyc - acc_cyc, LAT);
          check_eq("ready_id", req1_ready, exp_g);
          check_eq("rdata", obs_w, exp_w);
          check_eq("frame_cmd_addr", fl_sh, {8'h03, exp_fa});
          check_eq("frame_bits", fl_cnt, 64);
          check_eq("mosi_read_zero", fl_mosi_rd, 0);
          check_eq("sclk_timing_ok", fl_bad, 0);
          check_eq("done_cs", spi_cs, 1);
          check_eq("done_sclk", spi_clk, 0);
          if (exp_g) begin hold1 = exp_w; n_ready1++; end
          else begin hold0 = exp_w; n_ready0++; end
          gnt_log.push_back(int'(exp_g)); acc_log.push_back(acc_cyc);
          rdy_log.push_back(cyc); rd_log.push_back(obs_w);
          pending = 1'b0; rdy_cyc = cyc;
        end
      end
      check_eq("rdata0_hold", req0_rdata, hold0);
      check_eq("rdata1_hold", req1_rdata, hold1);
      check_eq("busy", busy, pending || (cyc - rdy_cyc <= 2));
      if (!pending && !busy && (req0_valid || req1_valid)) begin
        exp_g   = (req0_valid && req1_valid) ? !last_g : req1_valid;
        last_g  = exp_g;
        acc_cyc = cyc;
        exp_fa  = 24'((BASE + 32'(exp_g ? req1_addr : req0_addr)) % 32'h1000000);
        pending = 1'b1;
      end else if (pending && (cyc - acc_cyc > LAT)) begin
        check_eq("ready_timeout", cyc - acc_cyc, LAT);
        pending = 1'b0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cs"}, spi_cs, 1);
    check_eq({tag, "_sclk"}, spi_clk, 0);
    check_eq({tag, "_mosi"}, spi_mosi, 0);
    check_eq({tag, "_rdy0"}, req0_ready, 0);
    check_eq({tag, "_rdy1"}, req1_ready, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_rd0"}, req0_rdata, 0);
    check_eq({tag, "_rd1"}, req1_rdata, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 n_reset = 1'b0;
    #1 check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1 n_reset = 1'b1;
  endtask

  // One requester issuing n reads, holding valid/addr until its ready pulse.
  task automatic req_txns(input int id, input int n, input logic rand_addr,
                          input logic [23:0] a0, input int max_dly);
    for (int k = 0; k < n; k++) begin
      int t;
      logic [23:0] a;
      a = rand_addr ? 24'($urandom) : a0;
      repeat (max_dly > 0 ? $urandom_range(0, max_dly) : 0) @(posedge clk);
      @(posedge clk);
      #1;
      if (id == 0) begin req0_valid = 1'b1; req0_addr = a; end
      else begin req1_valid = 1'b1; req1_addr = a; end
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!(id == 0 ? req0_ready : req1_ready) && t < 3 * LAT);
      check_eq(id == 0 ? "req0_wait" : "req1_wait", id == 0 ? req0_ready : req1_ready, 1);
      @(posedge clk);
      #1;
      if (id == 0) req0_valid = 1'b0;
      else req1_valid = 1'b0;
    end
  endtask

  task automatic wait_pending(input string tag);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (!pending && t < 50);
    check_eq(tag, pending, 1);
  endtask

  task automatic wait_ready(input int id, input string tag);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(id == 0 ? req0_ready : req1_ready) && t < 2 * LAT);
    check_eq(tag, id == 0 ? req0_ready : req1_ready, 1);
  endtask

  initial begin
    int n, b0, b1;
    salt = 8'($urandom);
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("por");
    n_reset = 1'b1;

    // Directed single read with a fixed flash pattern.
    fixed_mode = 1'b1;
    req_txns(0, 1, 1'b0, 24'h000010, 0);
    check_eq("single_rdata", rd_log[$], 32'h44332211);
    check_eq("single_frame", fl_sh, 32'h03500010);
    fixed_mode = 1'b0;

    // Tie straight after reset: requester 0 first, requester 1 accepted 3 cycles after ready.
    do_reset();
    n = gnt_log.size();
    fork
      req_txns(0, 1, 1'b1, '0, 0);
      req_txns(1, 1, 1'b1, '0, 0);
    join
    check_eq("tie_count", gnt_log.size() - n, 2);
    if (gnt_log.size() >= n + 2) begin
      check_eq("tie_first", gnt_log[n], 0);
      check_eq("tie_second", gnt_log[n + 1], 1);
      check_eq("tie_gap", acc_log[n + 1] - rdy_log[n], 3);
    end

    // Fairness with both requesters continuously asking.
    n = gnt_log.size();
    fork
      req_txns(0, 2, 1'b1, '0, 0);
      req_txns(1, 2, 1'b1, '0, 0);
    join
    check_eq("fair_count", gnt_log.size() - n, 4);
    if (gnt_log.size() >= n + 4) begin
      check_eq("fair_order", {gnt_log[n][0], gnt_log[n + 1][0], gnt_log[n + 2][0],
                              gnt_log[n + 3][0]}, 4'b0101);
    end

    // Address wrap past 2^24.
    req_txns(1, 1, 1'b0, 24'hB00005, 0);
    check_eq("wrap_addr", fl_sh[23:0], 24'h000005);

    // Reset during bit 20 aborts the frame; the held request is served afresh.
    b0 = n_ready0;
    @(posedge clk);
    #1 req0_valid = 1'b1; req0_addr = 24'($urandom);
    wait_pending("abort_accept");
    repeat (1 + 20 * 2 * CLK_DIV) @(posedge clk);
    #2 n_reset = 1'b0;
    #1 check_reset_outputs("abort");
    repeat (2) @(posedge clk);
    #1 n_reset = 1'b1;
    wait_ready(0, "abort_reframe");
    @(posedge clk);
    #1 req0_valid = 1'b0;
    check_eq("abort_ready_count", n_ready0 - b0, 1);

    // Valid dropped and address changed mid-frame.
    b1 = n_ready1;
    @(posedge clk);
    #1 req1_valid = 1'b1; req1_addr = 24'($urandom);
    wait_pending("drop_accept");
    repeat (10) @(posedge clk);
    #1 req1_valid = 1'b0; req1_addr = ~req1_addr;
    wait_ready(1, "drop_ready");
    repeat (10) @(posedge clk);
    check_eq("drop_ready_count", n_ready1 - b1, 1);

    // Random traffic from both requesters.
    b0 = n_ready0;
    b1 = n_ready1;
    fork
      req_txns(0, 6, 1'b1, '0, 6);
      req_txns(1, 6, 1'b1, '0, 6);
    join
    check_eq("rand_count0", n_ready0 - b0, 6);
    check_eq("rand_count1", n_ready1 - b1, 6);

    repeat (20) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(50000 * PERIOD);
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1);
  end

endmodule
